// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: a+b+cin computed LSB first through a single fulladd cell.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.

module fulladd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;
  logic             accept;

  assign ready  = (state != RUN);
  assign done   = (state == DONE);
  assign accept = start & ready;
  assign sum    = sum_sr;
  // After the last RUN edge the carry register holds the carry out of the MSB.
  assign cout   = carry;

  fulladd u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= fa_co;
      cnt    <= cnt + 1'b1;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // Carry into the MSB is the fulladd carry-in during the final RUN cycle.
  logic c_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          c_msb <= 1'b0;
    else if (state == RUN && cnt == LAST) c_msb <= carry;
  end

  assign ovf = c_msb ^ carry;
`endif

endmodule
